// File: rtl/uart_word_packer_if.sv
// Byte-FIFO and word-handshake bundle around uart_word_packer.
// slave is the packer's view; master is the view of everything around it.
interface uart_word_packer_if #(
  parameter int DATA_LEN = 8,
  parameter int WORD_LEN = 32
);
  logic                i_rxEmpty;
  logic [DATA_LEN-1:0] i_rxData;
  logic                o_rxRead;
  logic [WORD_LEN-1:0] o_rxWord;
  logic                o_rxWordValid;
  logic                i_rxWordReady;
  logic [WORD_LEN-1:0] i_txWord;
  logic                i_txWordValid;
  logic                o_txWordReady;
  logic                i_txFull;
  logic                o_txWrite;
  logic [DATA_LEN-1:0] o_txData;
  logic                o_rxTimeout;

  modport slave (
    input  i_rxEmpty, i_rxData, i_rxWordReady, i_txWord, i_txWordValid, i_txFull,
    output o_rxRead, o_rxWord, o_rxWordValid, o_txWordReady, o_txWrite, o_txData,
           o_rxTimeout
  );

  modport master (
    output i_rxEmpty, i_rxData, i_rxWordReady, i_txWord, i_txWordValid, i_txFull,
    input  o_rxRead, o_rxWord, o_rxWordValid, o_txWordReady, o_txWrite, o_txData,
           o_rxTimeout
  );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART RX bytes into little-endian words and unpacks TX words into bytes.
// Define RX_TIMEOUT_EN to drop partial RX words after TIMEOUT_CYCLES idle cycles.
module uart_word_packer #(
  parameter int DATA_LEN       = 8,
  parameter int WORD_BYTES     = 4,
  parameter int WORD_LEN       = 32,
  parameter int CNT_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_BITS   = 17
) (
  input logic               i_clk,
  input logic               i_reset,
  uart_word_packer_if.slave bus
);

  typedef enum logic {COLLECT, HOLD} rxState_t;
  typedef enum logic {IDLE, SEND} txState_t;

  rxState_t rxState, rxNext;
  txState_t txState, txNext;

  logic [WORD_BYTES-1:0][DATA_LEN-1:0] rxLanes;
  logic [WORD_BYTES-1:0][DATA_LEN-1:0] txLanes;
  logic [CNT_BITS-1:0] rxCnt, txCnt;
  logic rxPop, rxLast, txPush, txLast;

  assign rxLast = (rxCnt == CNT_BITS'(WORD_BYTES - 1));
  assign txLast = (txCnt == CNT_BITS'(WORD_BYTES - 1));

  // Pops and pushes are gated by reset so nothing leaks into the FIFOs while held.
  always_comb begin
    rxNext = rxState;
    rxPop  = 1'b0;
    case (rxState)
      COLLECT: begin
        rxPop = !bus.i_rxEmpty && i_reset;
        if (rxPop && rxLast) rxNext = HOLD;
      end
      HOLD:    if (bus.i_rxWordReady) rxNext = COLLECT;
      default: rxNext = COLLECT;
    endcase
  end

`ifdef RX_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] timeoutCnt;
  logic timeoutHit;
  logic rxTimeoutPulse;

  assign timeoutHit = (rxState == COLLECT) && (rxCnt != '0) && !rxPop &&
                      (timeoutCnt == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      timeoutCnt     <= '0;
      rxTimeoutPulse <= 1'b0;
    end else begin
      rxTimeoutPulse <= timeoutHit;
      if (rxState != COLLECT || rxCnt == '0 || rxPop || timeoutHit) timeoutCnt <= '0;
      else timeoutCnt <= timeoutCnt + TIMEOUT_BITS'(1);
    end
  end

  assign bus.o_rxTimeout = rxTimeoutPulse;
`else
  assign bus.o_rxTimeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rxState <= COLLECT;
      rxCnt   <= '0;
      rxLanes <= '0;
    end else begin
      rxState <= rxNext;
      if (rxPop) begin
        rxLanes[rxCnt] <= bus.i_rxData;
        rxCnt          <= rxLast ? '0 : rxCnt + CNT_BITS'(1);
      end
`ifdef RX_TIMEOUT_EN
      else if (timeoutHit) rxCnt <= '0;
`endif
    end
  end

  assign bus.o_rxRead      = rxPop;
  assign bus.o_rxWordValid = (rxState == HOLD);
  assign bus.o_rxWord      = rxLanes;

  always_comb begin
    txNext = txState;
    txPush = 1'b0;
    case (txState)
      IDLE:    if (bus.i_txWordValid) txNext = SEND;
      SEND: begin
        txPush = !bus.i_txFull && i_reset;
        if (txPush && txLast) txNext = IDLE;
      end
      default: txNext = IDLE;
    endcase
  end

  // A full TX FIFO simply freezes txCnt, so the stalled byte is neither lost nor repeated.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      txState <= IDLE;
      txCnt   <= '0;
      txLanes <= '0;
    end else begin
      txState <= txNext;
      if (txState == IDLE && bus.i_txWordValid) begin
        txLanes <= bus.i_txWord;
        txCnt   <= '0;
      end else if (txPush) begin
        txCnt <= txLast ? '0 : txCnt + CNT_BITS'(1);
      end
    end
  end

  assign bus.o_txWordReady = (txState == IDLE);
  assign bus.o_txWrite     = txPush;
  assign bus.o_txData      = (txState == SEND) ? txLanes[txCnt] : '0;

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer: RX packing, hold, TX unpacking, stalls, reset, timeout.
// An RX FIFO model feeds bytes; negedge monitors log everything the DUT emits.
module tb_uart_word_packer;
  localparam int DATA_LEN = 8, WORD_BYTES = 4, WORD_LEN = 32, CNT_BITS = 2;
  localparam int TIMEOUT_CYCLES = 16, TIMEOUT_BITS = 17;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int checkCount = 0;
  int errorCount = 0;

  uart_word_packer_if #(.DATA_LEN(DATA_LEN), .WORD_LEN(WORD_LEN)) bus ();

  uart_word_packer #(
    .DATA_LEN(DATA_LEN), .WORD_BYTES(WORD_BYTES), .WORD_LEN(WORD_LEN),
    .CNT_BITS(CNT_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .i_clk  (clk),
    .i_reset(resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // First-word-fall-through RX FIFO model; the head advances after the DUT samples it.
  logic [7:0] rxMem [0:255];
  int rxTail = 0;
  int rxHead = 0;
  assign bus.i_rxEmpty = (rxHead == rxTail);
  assign bus.i_rxData  = rxMem[rxHead[7:0]];
  always @(posedge clk) if (bus.o_rxRead) rxHead <= rxHead + 1;

  int rxReadCount = 0, validCycles = 0, fullWrites = 0, timeoutPulses = 0;
  logic [31:0] wordLog [$];
  logic [7:0]  txLog [$];

  always @(negedge clk) begin
    if (bus.o_rxRead) rxReadCount++;
    if (bus.o_rxWordValid) validCycles++;
    if (bus.o_rxWordValid && bus.i_rxWordReady) wordLog.push_back(bus.o_rxWord);
    if (bus.o_txWrite) txLog.push_back(bus.o_txData);
    if (bus.o_txWrite && bus.i_txFull) fullWrites++;
    if (bus.o_rxTimeout) timeoutPulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] logWord(input int i);
    if (i < wordLog.size()) return wordLog[i];
    return 'x;
  endfunction

  function automatic logic [7:0] logByte(input int i);
    if (i < txLog.size()) return txLog[i];
    return 'x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushRx(input logic [7:0] b);
    rxMem[rxTail[7:0]] = b;
    rxTail++;
  endtask

  task automatic sendTxWord(input logic [31:0] w);
    bus.i_txWord      = w;
    bus.i_txWordValid = 1'b1;
    tick(1);
    bus.i_txWordValid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Valid"}, bus.o_rxWordValid, 0);
    checkOutput({tag, "Word"}, bus.o_rxWord, 0);
    checkOutput({tag, "TxReady"}, bus.o_txWordReady, 1);
    checkOutput({tag, "TxWrite"}, bus.o_txWrite, 0);
    checkOutput({tag, "TxData"}, bus.o_txData, 0);
    checkOutput({tag, "RxRead"}, bus.o_rxRead, 0);
    checkOutput({tag, "Timeout"}, bus.o_rxTimeout, 0);
  endtask

  initial begin
    int base, vBase, wBase, tBase, pBase, n, stallBad, holdBad;
    logic [7:0] bytesExp [4];
    bytesExp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    bus.i_rxWordReady = 1'b0;
    bus.i_txWord      = '0;
    bus.i_txWordValid = 1'b0;
    bus.i_txFull      = 1'b0;

    repeat (2) @(negedge clk);
    checkResetOutputs("rst");
    @(negedge clk);
    resetN = 1'b1;
    tick(1);

    // Back-to-back word with consumer always ready
    base = rxReadCount; vBase = validCycles; wBase = wordLog.size();
    bus.i_rxWordReady = 1'b1;
    pushRx(8'h78); pushRx(8'h56); pushRx(8'h34); pushRx(8'h12);
    tick(8);
    checkOutput("t1Reads", rxReadCount - base, 4);
    checkOutput("t1ValidCycles", validCycles - vBase, 1);
    checkOutput("t1Words", wordLog.size() - wBase, 1);
    checkOutput("t1Word", logWord(wBase), 32'h12345678);

    // Consumer stalls while eight bytes are queued
    bus.i_rxWordReady = 1'b0;
    base = rxReadCount; wBase = wordLog.size();
    for (int i = 1; i <= 8; i++) pushRx(8'(i));
    n = 0;
    while (!bus.o_rxWordValid && n < 50) begin @(negedge clk); n++; end
    checkOutput("t2ValidSeen", bus.o_rxWordValid, 1);
    vBase = rxReadCount; holdBad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_rxWord !== 32'h04030201 || bus.o_rxWordValid !== 1'b1) holdBad++;
    end
    checkOutput("t2HoldReads", rxReadCount - vBase, 0);
    checkOutput("t2HoldStable", holdBad, 0);
    @(posedge clk); #1;
    bus.i_rxWordReady = 1'b1;
    tick(12);
    checkOutput("t2Reads", rxReadCount - base, 8);
    checkOutput("t2Words", wordLog.size() - wBase, 2);
    checkOutput("t2Word0", logWord(wBase), 32'h04030201);
    checkOutput("t2Word1", logWord(wBase + 1), 32'h08070605);

    // TX unpack, LSB lane first
    tick(1);
    sendTxWord(32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t3Byte%0d", i),
                  {bus.o_txWrite, bus.o_txWordReady, bus.o_txData}, {1'b1, 1'b0, bytesExp[i]});
    end
    @(negedge clk);
    checkOutput("t3ReadyAfter", {bus.o_txWrite, bus.o_txWordReady}, 2'b01);

    // TX FIFO full for five cycles after the second byte
    tick(1);
    tBase = txLog.size(); base = fullWrites;
    sendTxWord(32'hDEADBEEF);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    bus.i_txFull = 1'b1;
    stallBad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_txWrite !== 1'b0 || bus.o_txData !== 8'hAD) stallBad++;
    end
    @(posedge clk); #1;
    bus.i_txFull = 1'b0;
    tick(6);
    checkOutput("t4Stall", stallBad, 0);
    checkOutput("t4FullWrites", fullWrites - base, 0);
    checkOutput("t4Bytes", txLog.size() - tBase, 4);
    checkOutput("t4Byte1", logByte(tBase + 1), 8'hBE);
    checkOutput("t4Byte2", logByte(tBase + 2), 8'hAD);
    checkOutput("t4Byte3", logByte(tBase + 3), 8'hDE);

    // Reset in the middle of an RX word and a TX word
    pushRx(8'h99); pushRx(8'h98);
    sendTxWord(32'h01020304);
    tick(1);
    resetN = 1'b0;
    tBase = txLog.size(); vBase = validCycles;
    @(negedge clk);
    checkResetOutputs("t5Rst");
    @(negedge clk);
    resetN = 1'b1;
    tick(4);
    checkOutput("t5NoTxAfter", txLog.size() - tBase, 0);
    checkOutput("t5NoValid", validCycles - vBase, 0);
    checkOutput("t5TxReady", bus.o_txWordReady, 1);
    wBase = wordLog.size();
    pushRx(8'hAA); pushRx(8'hBB); pushRx(8'hCC); pushRx(8'hDD);
    tick(8);
    checkOutput("t5Words", wordLog.size() - wBase, 1);
    checkOutput("t5Word", logWord(wBase), 32'hDDCCBBAA);

    // Idle partial word: dropped with the timeout build, kept otherwise
    wBase = wordLog.size(); pBase = timeoutPulses;
    pushRx(8'h11);
    tick(20);
`ifdef RX_TIMEOUT_EN
    checkOutput("t6Pulses", timeoutPulses - pBase, 1);
    pushRx(8'h11);
`else
    checkOutput("t6Pulses", timeoutPulses - pBase, 0);
`endif
    pushRx(8'h22); pushRx(8'h33); pushRx(8'h44);
    tick(8);
    checkOutput("t6Words", wordLog.size() - wBase, 1);
    checkOutput("t6Word", logWord(wBase), 32'h44332211);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
